gate_op_arbiter: RTL

Round-robin arbiter and sequencer that shares one `gates` unit between up to N requesters. The `gates` unit has inputs `a` and `b` and outputs y1..y6 = AND, OR, NAND, NOR, XOR, XNOR. Each requester presents an operand pair and an opcode. The block grants one requester at a time, drives the shared `gates` instance from registered operands, selects the requested output, and returns a tagged result with a valid pulse. It sits between client logic and the single `gates` instance, which it instantiates internally.

---
 rtl/gate_op_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/gate_op_arbiter.sv
// ---------------------------------------------------------------------------
// gate_op_arbiter
//
// Shares one combinational `gates` unit (AND/OR/NAND/NOR/XOR/XNOR) between up
// to N_REQ requesters. A round-robin arbiter picks one requester while the FSM
// is IDLE and latches that requester's operands and opcode. The FSM then runs
// the gates unit from the latched values (EXEC) and presents a tagged result
// (DONE). Only one transaction is in flight at any time.
//
// Ports:
//   clk      - sole clock, rising edge
//   rst      - synchronous active-high reset
//   req      - per-requester request level, sampled only in IDLE
//   a_in     - operand a, bit i belongs to requester i
//   b_in     - operand b, bit i belongs to requester i
//   op_in    - opcode, bits [3i+2:3i] belong to requester i
//   gnt      - one-hot grant, single-cycle pulse during EXEC
//   y_out    - selected gate result, held between transactions
//   y_valid  - result strobe, single-cycle pulse during DONE
//   y_id     - index of the requester owning the result
//   err      - illegal opcode (6 or 7), qualified by y_valid
//   txn_cnt  - completed transactions, wraps 255 -> 0
// ---------------------------------------------------------------------------

// The shared logic unit: every two-input gate computed in parallel.
module gates (
    input  logic a,
    input  logic b,
    output logic y1,
    output logic y2,
    output logic y3,
    output logic y4,
    output logic y5,
    output logic y6
);
    assign y1 = a & b;
    assign y2 = a | b;
    assign y3 = ~(a & b);
    assign y4 = ~(a | b);
    assign y5 = a ^ b;
    assign y6 = ~(a ^ b);
endmodule

module gate_op_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   a_in,
    input  logic [N_REQ-1:0]   b_in,
    input  logic [3*N_REQ-1:0] op_in,
    output logic [N_REQ-1:0]   gnt,
    output logic               y_out,
    output logic               y_valid,
    output logic [ID_W-1:0]    y_id,
    output logic               err,
    output logic [7:0]         txn_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t             state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    winId_q;
    logic               aLat_q;
    logic               bLat_q;
    logic [2:0]         opLat_q;
    logic [N_REQ-1:0]   gnt_q;
    logic               yOut_q;
    logic               yValid_q;
    logic [ID_W-1:0]    yId_q;
    logic               err_q;
    logic [7:0]         txnCnt_q;

    logic [ID_W-1:0]    winner_d;
    logic [ID_W-1:0]    ptrNext_d;
    logic               yRes_d;
    logic               errRes_d;
    logic               g1, g2, g3, g4, g5, g6;

    // Round-robin search: scan requesters starting at ptr_q and wrapping,
    // taking the first one with its request raised. The pointer sits one past
    // the previous winner, so the last winner is always searched last.
    always_comb begin
        int  idx;
        logic found;
        winner_d = ptr_q;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                winner_d = ID_W'(idx);
            end
        end
    end

    // Pointer advances to the requester just after the winner, wrapping.
    assign ptrNext_d = (winId_q == ID_W'(N_REQ - 1)) ? '0 : winId_q + ID_W'(1);

    // The shared unit only ever sees latched operands, so requester inputs
    // changing after the sampling edge cannot disturb the transaction.
    gates uGates (
        .a  (aLat_q),
        .b  (bLat_q),
        .y1 (g1),
        .y2 (g2),
        .y3 (g3),
        .y4 (g4),
        .y5 (g5),
        .y6 (g6)
    );

    // Opcode selects one gate output; opcodes 6 and 7 force a 0 result and
    // raise the error flag.
    always_comb begin
        yRes_d   = 1'b0;
        errRes_d = 1'b0;
        case (opLat_q)
            3'd0:    yRes_d = g1;
            3'd1:    yRes_d = g2;
            3'd2:    yRes_d = g3;
            3'd3:    yRes_d = g4;
            3'd4:    yRes_d = g5;
            3'd5:    yRes_d = g6;
            default: errRes_d = 1'b1;
        endcase
    end

    // Sequencer. All outputs are registered: gnt is loaded on the IDLE->EXEC
    // edge so it is high for the EXEC cycle; the result, tag, strobe and
    // counter are loaded on the EXEC->DONE edge so they are visible in DONE.
    // Reset clears everything, so an aborted transaction never strobes and
    // never reaches the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            winId_q  <= '0;
            aLat_q   <= 1'b0;
            bLat_q   <= 1'b0;
            opLat_q  <= 3'd0;
            gnt_q    <= '0;
            yOut_q   <= 1'b0;
            yValid_q <= 1'b0;
            yId_q    <= '0;
            err_q    <= 1'b0;
            txnCnt_q <= 8'd0;
        end else begin
            gnt_q    <= '0;
            yValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        aLat_q  <= a_in[winner_d];
                        bLat_q  <= b_in[winner_d];
                        opLat_q <= op_in[int'(winner_d)*3 +: 3];
                        winId_q <= winner_d;
                        gnt_q   <= N_REQ'(1) << winner_d;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    yOut_q   <= yRes_d;
                    err_q    <= errRes_d;
                    yValid_q <= 1'b1;
                    yId_q    <= winId_q;
                    txnCnt_q <= txnCnt_q + 8'd1;
                    state_q  <= DONE;
                end
                DONE: begin
                    ptr_q   <= ptrNext_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign y_out   = yOut_q;
    assign y_valid = yValid_q;
    assign y_id    = yId_q;
    assign err     = err_q;
    assign txn_cnt = txnCnt_q;

endmodule
